// File: rtl/imem_loader_if.sv
// Byte-stream load port and instruction-memory write port of the program loader.
// The slave modport is the loader's view; master is the host/driver view.
interface imem_loader_if;
  logic        start;
  logic [7:0]  length_words;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_hold;

  modport master (
    output start, length_words, byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata, busy, done, err, cpu_hold
  );

  modport slave (
    input  start, length_words, byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata, busy, done, err, cpu_hold
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles little-endian bytes into 32-bit words and writes them.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH = 45
) (
  input logic         clk,
  input logic         rst,
  imem_loader_if.slave bus
);

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE} state_t;
`endif

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  length;
  logic [7:0]  word_index;
  logic [7:0]  csum;
  logic [1:0]  lane;
  logic [23:0] word_buf;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        err_r;

  logic        byte_ready;
  logic        mem_we;
  logic        busy;
  logic        done;
  logic        cpu_hold;
  logic        start_ok;
  logic        start_bad;
  logic        acc;
  logic        len_ok;
  logic        last_word;

  assign len_ok    = (bus.length_words != 8'd0) && ({24'd0, bus.length_words} <= DEPTH_U);
  assign acc       = byte_ready && bus.byte_valid;
  assign last_word = ((word_index + 8'd1) == length);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    cpu_hold   = 1'b1;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (state == DONE) begin
          done     = 1'b1;
          cpu_hold = 1'b0;
        end
        // A rejected start from DONE drops back to IDLE so the stale image is not reported as loaded.
        if (bus.start) begin
          if (len_ok) begin
            start_ok  = 1'b1;
            state_nxt = RECV;
          end else begin
            start_bad = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      RECV: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (bus.byte_valid && (lane == 2'd3)) state_nxt = WRITE;
      end
      WRITE: begin
        mem_we = 1'b1;
        busy   = 1'b1;
        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nxt = CHECK;
`else
          state_nxt = DONE;
`endif
        end else begin
          state_nxt = RECV;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (bus.byte_valid) state_nxt = DONE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      length     <= 8'd0;
      word_index <= 8'd0;
      lane       <= 2'd0;
      csum       <= 8'd0;
      err_r      <= 1'b0;
      addr_r     <= 32'd0;
      wdata_r    <= 32'd0;
    end else begin
      if (start_ok) begin
        length     <= bus.length_words;
        word_index <= 8'd0;
        lane       <= 2'd0;
        csum       <= 8'd0;
        err_r      <= 1'b0;
      end else if (start_bad) begin
        err_r <= 1'b1;
      end
      // The fourth byte goes straight into the write register so mem_we can follow on the next cycle.
      if (acc && (state == RECV)) begin
        lane <= lane + 2'd1;
        csum <= csum + bus.byte_in;
        if (lane == 2'd3) begin
          addr_r  <= {22'd0, word_index, 2'b00};
          wdata_r <= {bus.byte_in, word_buf};
        end
      end
      if (state == WRITE) word_index <= word_index + 8'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (acc && (state == CHECK) && (8'(csum + bus.byte_in) != 8'd0)) err_r <= 1'b1;
`endif
    end
  end

  // Lower lanes need no reset: lane returns to 0 on reset, so stale bytes are always overwritten.
  always_ff @(posedge clk) begin
    if (acc && (state == RECV)) begin
      case (lane)
        2'd0:    word_buf[7:0]   <= bus.byte_in;
        2'd1:    word_buf[15:8]  <= bus.byte_in;
        2'd2:    word_buf[23:16] <= bus.byte_in;
        default: ;
      endcase
    end
  end

  assign bus.byte_ready = byte_ready;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = addr_r;
  assign bus.mem_wdata  = wdata_r;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.err        = err_r;
  assign bus.cpu_hold   = cpu_hold;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: loads are checked against a byte-list reference model.
module tb_imem_loader;
  localparam int DEPTH = 45;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [7:0]  data_q[$];

  imem_loader_if bus();

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr_q.push_back(bus.mem_addr);
      wr_data_q.push_back(bus.mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rdy"},   bus.byte_ready, 0);
    check({tag, "_we"},    bus.mem_we,     0);
    check({tag, "_addr"},  bus.mem_addr,   0);
    check({tag, "_wdata"}, bus.mem_wdata,  0);
    check({tag, "_busy"},  bus.busy,       0);
    check({tag, "_done"},  bus.done,       0);
    check({tag, "_err"},   bus.err,        0);
    check({tag, "_hold"},  bus.cpu_hold,   1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int gap;
    int n;
    gap = $urandom_range(0, 3);
    n = 0;
    repeat (gap) begin
      bus.byte_in = 8'($urandom);
      @(posedge clk); #1;
    end
    bus.byte_valid = 1'b1;
    bus.byte_in    = b;
    @(negedge clk);
    while (bus.byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("hs_ready", bus.byte_ready, 1);
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'($urandom);
  endtask

  task automatic pulse_start(input logic [7:0] len);
    @(posedge clk); #1;
    bus.start        = 1'b1;
    bus.length_words = len;
    @(posedge clk); #1;
    bus.start        = 1'b0;
    bus.length_words = 8'($urandom);
  endtask

  task automatic fill_random(input int L);
    data_q.delete();
    for (int i = 0; i < 4 * L; i++) data_q.push_back(8'($urandom));
  endtask

  // Reference: word i is bytes 4i..4i+3 little-endian at byte address 4i; checksum is an 8-bit sum.
  task automatic run_load(input int L, input bit poke, input bit cs_bad, input string tag);
    logic [7:0]  sum;
    logic [31:0] w;
    bit          err_exp;
    int          n;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  cs;
`endif
    sum = 8'd0;
    err_exp = 1'b0;
    n = 0;
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start(8'(L));
    check({tag, "_busy_run"}, bus.busy,     1);
    check({tag, "_hold_run"}, bus.cpu_hold, 1);
    check({tag, "_done_run"}, bus.done,     0);
    for (int i = 0; i < 4 * L; i++) begin
      send_byte(data_q[i]);
      sum = sum + data_q[i];
      if (poke && i == 1) pulse_start(8'd1);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    cs = cs_bad ? 8'h00 : (8'h00 - sum);
    send_byte(cs);
    err_exp = (8'(sum + cs) != 8'd0);
`endif
    while (bus.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, bus.done,       1);
    check({tag, "_busy"}, bus.busy,       0);
    check({tag, "_hold"}, bus.cpu_hold,   0);
    check({tag, "_rdy"},  bus.byte_ready, 0);
    check({tag, "_err"},  bus.err,        {31'd0, err_exp});
    check({tag, "_nwr"},  wr_addr_q.size(), L);
    for (int i = 0; i < L; i++) begin
      w = {data_q[4*i+3], data_q[4*i+2], data_q[4*i+1], data_q[4*i]};
      if (i < wr_addr_q.size()) begin
        check({tag, "_addr"}, wr_addr_q[i], 32'(4 * i));
        check({tag, "_data"}, wr_data_q[i], w);
      end
    end
    w = {data_q[4*L-1], data_q[4*L-2], data_q[4*L-3], data_q[4*L-4]};
    check({tag, "_addr_hold"},  bus.mem_addr,  32'(4 * (L - 1)));
    check({tag, "_wdata_hold"}, bus.mem_wdata, w);
  endtask

  initial begin
    int L;
    bus.start        = 1'b0;
    bus.length_words = 8'd0;
    bus.byte_in      = 8'd0;
    bus.byte_valid   = 1'b0;
    #2 rst = 1'b1;
    #2 check_reset("por");
    @(posedge clk); #1;
    rst = 1'b0;
    check("idle_rdy",  bus.byte_ready, 0);
    check("idle_busy", bus.busy,       0);

    data_q = '{8'h13, 8'h00, 8'h00, 8'h00};
    run_load(1, 1'b0, 1'b0, "one");

    data_q = '{8'h93, 8'h00, 8'h10, 8'h00, 8'hB3, 8'h80, 8'h20, 8'h00};
    run_load(2, 1'b0, 1'b0, "two");

    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start(8'd0);
    check("len0_err",  bus.err,      1);
    check("len0_done", bus.done,     0);
    check("len0_busy", bus.busy,     0);
    check("len0_hold", bus.cpu_hold, 1);
    pulse_start(8'(DEPTH + 1));
    check("lenbig_err",  bus.err,        1);
    check("lenbig_rdy",  bus.byte_ready, 0);
    check("lenbig_busy", bus.busy,       0);
    pulse_start(8'd255);
    check("len255_err", bus.err, 1);
    check("badlen_nwr", wr_addr_q.size(), 0);

    fill_random(3);
    run_load(3, 1'b1, 1'b0, "poke");

`ifdef IMEM_LOADER_CHECKSUM_EN
    data_q = '{8'h13, 8'h00, 8'h00, 8'h00};
    run_load(1, 1'b0, 1'b1, "csbad");
`endif

    for (int k = 0; k < 4; k++) begin
      L = $urandom_range(1, 8);
      fill_random(L);
      run_load(L, k[0], 1'($urandom_range(0, 1)), "rnd");
    end

    fill_random(DEPTH);
    run_load(DEPTH, 1'b0, 1'b0, "full");

    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start(8'd2);
    send_byte(8'hAA);
    send_byte(8'h55);
    #3 rst = 1'b1;
    #1 check_reset("abort");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_nwr", wr_addr_q.size(), 0);

    fill_random(2);
    run_load(2, 1'b0, 1'b0, "after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 45, instruction-memory depth in 32-bit words.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle request to begin a load; sampled only in IDLE or DONE.
REQ-005 length_words  input  8  number of words to load, sampled with start.
REQ-006 byte_in  input  8  program byte stream, little-endian within each word.
REQ-007 byte_valid  input  1  byte_in holds a valid byte.
REQ-008 byte_ready  output  1  loader accepts byte_in this cycle.
REQ-009 mem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 mem_addr  output  32  byte address of the word written, same addressing as pc (word index << 2).
REQ-011 mem_wdata  output  32  assembled instruction word.
REQ-012 busy  output  1  load in progress.
REQ-013 done  output  1  load completed.
REQ-014 err  output  1  invalid length or checksum failure.
REQ-015 cpu_hold  output  1  holds core in reset/stall while program memory is invalid.

Function
REQ-016 States IDLE, RECV, WRITE, CHECK, DONE; encoding implementer's choice.
REQ-017 IDLE: byte_ready=0, busy=0; start with 1 <= length_words <= DEPTH latches length, clears word index, byte lane, err, goes RECV next cycle.
REQ-018 IDLE/DONE: start with length_words=0 or >DEPTH sets err=1, done=0, state becomes IDLE, no write occurs.
REQ-019 RECV: byte_ready=1, busy=1; a byte is accepted only when byte_valid && byte_ready on a rising edge.
REQ-020 Byte lane k (0..3) of the word takes the k-th accepted byte: first byte -> [7:0], fourth -> [31:24].
REQ-021 Fourth accepted byte moves to WRITE; byte_valid gaps of any length stall without losing state.
REQ-022 WRITE: exactly one cycle with mem_we=1, mem_addr=word_index*4, mem_wdata=assembled word, byte_ready=0.
REQ-023 After WRITE: word_index increments; if it equals length, go CHECK (checksum enabled) or DONE, else RECV.
REQ-024 Latency: mem_we asserts the cycle after the fourth byte handshake.
REQ-025 mem_addr never exceeds (DEPTH-1)*4; mem_we=0 outside WRITE; mem_addr/mem_wdata hold last values otherwise.
REQ-026 DONE: done=1, busy=0, cpu_hold=0, byte_ready=0; holds until start or rst.
REQ-027 start during RECV, WRITE or CHECK is ignored.
REQ-028 start in DONE with valid length clears done, asserts cpu_hold, restarts at word 0.
REQ-029 cpu_hold=1 in every state except DONE.

Reset
REQ-030 rst forces IDLE asynchronously; byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, cpu_hold=1.
REQ-031 rst mid-load aborts; partial word is discarded and never written; counters return to 0.

Configuration
REQ-032 Macro IMEM_LOADER_CHECKSUM_EN defined: after last WRITE, CHECK accepts one more byte with byte_ready=1; pass if 8-bit sum of all data bytes plus this byte is 0x00, else err=1; either way goes DONE.
REQ-033 Macro undefined: CHECK state absent, last WRITE goes directly to DONE, err only from length violation.

Verification
REQ-034 rst, start, length_words=1, bytes 13,00,00,00 -> one mem_we, mem_addr=0, mem_wdata=0x00000013, done=1, cpu_hold=0 (checksum on: extra byte 0xED -> err=0).
REQ-035 length_words=2, bytes 93,00,10,00,B3,80,20,00 with byte_valid gaps -> writes 0x00100093@0x0, 0x002080B3@0x4, no extra writes.
REQ-036 start with length_words=0, then 46 (DEPTH=45) -> err=1, no mem_we, state IDLE.
REQ-037 rst asserted after 2 bytes of word 1 -> all outputs at reset values immediately, no write; next load starts at mem_addr=0.
REQ-038 Checksum on, length 1, bytes 13,00,00,00, checksum 0x00 -> err=1, done=1.
REQ-039 start pulsed during RECV -> ignored, load completes normally with correct word count.
